// File: rtl/pcie_recv_pkg.sv
// Shared definitions for the PCIe receive path: word width, default
// thresholds and the control FSM state encoding.
package pcie_recv_pkg;

  localparam int DATA_W = 6;

  localparam logic [1:0] UMBRAL_IN_DEF = 2'd1;
  localparam logic [3:0] UMBRAL_VC_DEF = 4'd2;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/pcie_recv_sync_fifo.sv
// Single-clock show-ahead FIFO; a write to a full FIFO is accepted only
// when a read frees an entry in the same cycle, otherwise it is dropped.
module sync_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & ~do_push;
  assign dout     = mem[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset so it maps onto RAM; stale contents are never
  // observable because reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pcie_recv.sv
// PCIe receive path: two lane FIFOs merged round-robin into two virtual
// channel queues, drained with strict VC0 priority under consumer pops.
module pcie_recv #(
  parameter int DATA_W   = pcie_recv_pkg::DATA_W,
  parameter int IN_DEPTH = 4,
  parameter int VC_DEPTH = 16,
  parameter int VC_BIT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [1:0]        umbral_in,
  input  logic [3:0]        umbral_vc,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in0,
  input  logic              valid_in1,
  output logic              pause_out0,
  output logic              pause_out1,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty_out,
  output logic              active_out,
  output logic              idle_out,
  output logic              error_out
);

  import pcie_recv_pkg::*;

  localparam int IN_CW = $clog2(IN_DEPTH) + 1;
  localparam int VC_CW = $clog2(VC_DEPTH) + 1;

  logic [DATA_W-1:0] lane_din   [2];
  logic [DATA_W-1:0] lane_head  [2];
  logic [IN_CW-1:0]  lane_count [2];
  logic [1:0]        lane_push, lane_pop, lane_full, lane_empty, lane_ovf;
  logic [1:0]        lane_pause, lane_tgt, lane_cand;

  logic [DATA_W-1:0] vc_head  [2];
  logic [VC_CW-1:0]  vc_count [2];
  logic [1:0]        vc_push, vc_pop, vc_full, vc_empty, vc_ovf;

  logic [DATA_W-1:0] move_word;
  logic [1:0]        grant;
  logic              grant_sel;
  logic              last_q, last_d;

  logic [1:0]        umbral_in_q;
  logic [3:0]        umbral_vc_q;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              any_overflow;

  assign lane_din[0] = data_in0;
  assign lane_din[1] = data_in1;
  assign lane_push   = {valid_in1, valid_in0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      sync_fifo #(.DATA_W(DATA_W), .DEPTH(IN_DEPTH)) u_lane (
        .clk      (clk),
        .reset    (reset),
        .push     (lane_push[gi]),
        .pop      (lane_pop[gi]),
        .din      (lane_din[gi]),
        .dout     (lane_head[gi]),
        .count    (lane_count[gi]),
        .full     (lane_full[gi]),
        .empty    (lane_empty[gi]),
        .overflow (lane_ovf[gi])
      );

      sync_fifo #(.DATA_W(DATA_W), .DEPTH(VC_DEPTH)) u_vc (
        .clk      (clk),
        .reset    (reset),
        .push     (vc_push[gi]),
        .pop      (vc_pop[gi]),
        .din      (move_word),
        .dout     (vc_head[gi]),
        .count    (vc_count[gi]),
        .full     (vc_full[gi]),
        .empty    (vc_empty[gi]),
        .overflow (vc_ovf[gi])
      );

      assign lane_pause[gi] = (IN_CW'(IN_DEPTH) - lane_count[gi]) <= IN_CW'(umbral_in_q);
      assign lane_tgt[gi]   = lane_head[gi][VC_BIT];
      // A lane may only move when its head word has room in its VC queue.
      assign lane_cand[gi]  = ~lane_empty[gi] & ~vc_full[lane_tgt[gi]];
    end
  endgenerate

  always_comb begin
    grant = lane_cand;
    if (&lane_cand) grant = last_q ? 2'b01 : 2'b10;
  end

  assign grant_sel  = grant[1];
  assign lane_pop   = grant;
  assign move_word  = lane_head[grant_sel];
  assign vc_push[0] = (|grant) & ~lane_tgt[grant_sel];
  assign vc_push[1] = (|grant) &  lane_tgt[grant_sel];
  assign last_d     = (|grant) ? grant_sel : last_q;

  assign vc_pop[0] = pop & ~vc_empty[0];
  assign vc_pop[1] = pop & vc_empty[0] & ~vc_empty[1];

  always_comb begin
    valid_out_d = |vc_pop;
    data_out_d  = data_out_q;
    if (vc_pop[0])      data_out_d = vc_head[0];
    else if (vc_pop[1]) data_out_d = vc_head[1];
  end

  assign empty_out    = (&lane_empty) & (&vc_empty);
  assign any_overflow = |lane_ovf;

  always_comb begin
    state_d    = state_q;
    idle_out   = 1'b0;
    active_out = 1'b0;
    error_out  = 1'b0;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE:   begin
        idle_out = 1'b1;
        if (!empty_out) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        active_out = 1'b1;
        if (empty_out) state_d = ST_IDLE;
      end
      default:   begin
        error_out = 1'b1;
        state_d   = ST_ERROR;
      end
    endcase
    if (init && state_q != ST_ERROR) state_d = ST_INIT;
    if (any_overflow) state_d = ST_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RESET;
      last_q      <= 1'b1;
      umbral_in_q <= UMBRAL_IN_DEF;
      umbral_vc_q <= UMBRAL_VC_DEF;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      if (state_q == ST_INIT) begin
        umbral_in_q <= umbral_in;
        umbral_vc_q <= umbral_vc;
      end
    end
  end

  assign pause_out0 = lane_pause[0];
  assign pause_out1 = lane_pause[1];
  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;

  // The VC threshold is held for later use; VC queues never overflow because
  // the arbiter refuses to move into a full queue.
  logic unused_ok;
  assign unused_ok = ^{umbral_vc_q, lane_full, vc_ovf, vc_count[0], vc_count[1]};

endmodule

// File: tb/tb_pcie_recv.sv
// Scoreboard bench for pcie_recv: expected output words are queued as
// stimulus is issued and a monitor checks every valid_out beat.
module tb_pcie_recv;

  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset, init, pop;
  logic [1:0]    umbral_in;
  logic [3:0]    umbral_vc;
  logic [DW-1:0] data_in0, data_in1;
  logic          valid_in0, valid_in1;
  logic          pause_out0, pause_out1;
  logic [DW-1:0] data_out;
  logic          valid_out, empty_out, active_out, idle_out, error_out;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  pcie_recv dut (
    .clk(clk), .reset(reset), .init(init), .umbral_in(umbral_in), .umbral_vc(umbral_vc),
    .data_in0(data_in0), .data_in1(data_in1), .valid_in0(valid_in0), .valid_in1(valid_in1),
    .pause_out0(pause_out0), .pause_out1(pause_out1), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .empty_out(empty_out),
    .active_out(active_out), .idle_out(idle_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && valid_out) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got %h required none", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_out !== mon_exp) begin
          bad++;
          $display("FAIL out_word: got %h required %h", data_out, mon_exp);
        end else begin
          $display("out data=%h", data_out);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic v0, input logic [DW-1:0] d0, input logic v1, input logic [DW-1:0] d1);
    valid_in0 = v0; data_in0 = d0; valid_in1 = v1; data_in1 = d1;
    $display("wr l0=%b:%h l1=%b:%h", v0, d0, v1, d1);
    tick();
    valid_in0 = 1'b0; valid_in1 = 1'b0;
  endtask

  task automatic expect_word(input logic [DW-1:0] d);
    exp_q.push_back(d);
  endtask

  task automatic drain(input string name);
    int n = 0;
    pop = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    pop = 1'b0;
    repeat (3) tick();
    check({name, "_drain_left"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    reset = 1'b0;
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    check("reinit_idle", idle_out, 1'b1);
  endtask

  task automatic fill_vc1_lane0();
    for (int i = 0; i < 16; i++) wr(1'b1, DW'(6'h10 + i), 1'b0, '0);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; pop = 1'b0;
    umbral_in = 2'd1; umbral_vc = 4'd2;
    data_in0 = '0; data_in1 = '0; valid_in0 = 1'b0; valid_in1 = 1'b0;

    // Reset state and init sequence
    repeat (2) tick();
    check("rst_data_out", data_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_empty", empty_out, 1);
    check("rst_pause", {pause_out0, pause_out1}, 0);
    check("rst_status", {idle_out, active_out, error_out}, 0);
    reset = 1'b0;
    tick();
    init = 1'b1;
    tick();
    check("init_status", {idle_out, active_out, error_out}, 0);
    init = 1'b0;
    tick();
    check("idle_after_init", {idle_out, active_out, error_out}, 3'b100);

    // Lane0 latency with pop held
    pop = 1'b1;
    expect_word(6'h05); expect_word(6'h15);
    valid_in0 = 1'b1; data_in0 = 6'h05;
    tick();
    data_in0 = 6'h15;
    tick();
    valid_in0 = 1'b0;
    check("lat_not_yet", valid_out, 0);
    tick();
    check("lat_three", valid_out, 1);
    check("busy_active", active_out, 1);
    repeat (6) tick();
    pop = 1'b0;
    check("back_idle", idle_out, 1);
    check("lat_queue_empty", exp_q.size(), 0);

    // Round robin order, lane0 first after reset (all VC1)
    do_reset();
    wr(1'b1, 6'h11, 1'b1, 6'h1A);
    wr(1'b1, 6'h13, 1'b1, 6'h1B);
    repeat (5) tick();
    expect_word(6'h11); expect_word(6'h1A); expect_word(6'h13); expect_word(6'h1B);
    drain("rr");

    // VC separation: VC0 words leave before any VC1 word
    for (int i = 1; i <= 4; i++) wr(1'b1, DW'(i), 1'b1, DW'(6'h10 + i));
    repeat (6) tick();
    for (int i = 1; i <= 4; i++) expect_word(DW'(i));
    for (int i = 1; i <= 4; i++) expect_word(DW'(6'h10 + i));
    drain("vc_prio");

    // VC1 full: lane0 stalls, lane1 VC0 traffic keeps moving
    fill_vc1_lane0();
    wr(1'b1, 6'h30, 1'b1, 6'h21);
    wr(1'b1, 6'h31, 1'b1, 6'h22);
    wr(1'b1, 6'h32, 1'b0, '0);
    repeat (3) tick();
    check("stall_pause0", pause_out0, 1);
    expect_word(6'h21); expect_word(6'h22);
    pop = 1'b1;
    repeat (2) tick();
    pop = 1'b0;
    repeat (2) tick();
    check("stall_after_vc0", pause_out0, 1);
    check("vc0_out_done", exp_q.size(), 0);
    expect_word(6'h10);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    repeat (2) tick();
    check("release_one", pause_out0, 0);
    wr(1'b1, 6'h33, 1'b0, '0);
    check("release_exact", pause_out0, 1);
    for (int i = 1; i < 16; i++) expect_word(DW'(6'h10 + i));
    for (int i = 0; i < 4; i++) expect_word(DW'(6'h30 + i));
    drain("stall");

    // Ingress overflow on lane1 while its VC is full
    do_reset();
    fill_vc1_lane0();
    wr(1'b0, '0, 1'b1, 6'h38);
    wr(1'b0, '0, 1'b1, 6'h39);
    check("pause1_two", pause_out1, 0);
    wr(1'b0, '0, 1'b1, 6'h3A);
    check("pause1_three", pause_out1, 1);
    wr(1'b0, '0, 1'b1, 6'h3B);
    check("full_no_err", error_out, 0);
    wr(1'b0, '0, 1'b1, 6'h3C);
    check("overflow_err", error_out, 1);
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    check("err_sticky_init", {idle_out, active_out, error_out}, 3'b001);
    for (int i = 0; i < 16; i++) expect_word(DW'(6'h10 + i));
    for (int i = 0; i < 4; i++) expect_word(DW'(6'h38 + i));
    drain("err_flow");
    check("err_after_drain", error_out, 1);
    do_reset();
    check("err_cleared", error_out, 0);

    // Reset mid-operation discards queued words
    for (int i = 1; i <= 4; i++) wr(1'b1, DW'(i), 1'b1, DW'(6'h10 + i));
    wr(1'b1, 6'h05, 1'b0, '0);
    repeat (4) tick();
    expect_word(6'h01);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    tick();
    check("pre_rst_data", data_out, 6'h01);
    check("pre_rst_busy", empty_out, 0);
    reset = 1'b1;
    pop = 1'b1;
    tick();
    check("midrst_empty", empty_out, 1);
    check("midrst_valid", valid_out, 0);
    check("midrst_data", data_out, 0);
    exp_q.delete();
    reset = 1'b0;
    repeat (6) tick();
    pop = 1'b0;
    check("midrst_no_stale", valid_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end

endmodule
